// File: rtl/program_loader_if.sv
// RAM write bus driven by the program loader: one-cycle write strobe with
// address and data that stay put between writes.
interface program_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  o_RAM_WE;
  logic [ADDR_WIDTH-1:0] o_RAM_ADDR;
  logic [DATA_WIDTH-1:0] o_RAM_DATA;

  modport master (output o_RAM_WE, output o_RAM_ADDR, output o_RAM_DATA);
  modport slave  (input  o_RAM_WE, input  o_RAM_ADDR, input  o_RAM_DATA);
endinterface

// File: rtl/program_loader.sv
// UART-fed boot loader: receives A5 / length / data / checksum frames and writes
// the data bytes into program RAM while holding the CPU.
module program_loader #(
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_LENGTH   = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic i_SYS_CLOCK,
  input  logic i_CLEAR_n,
  input  logic i_RX,
  output logic o_CPU_HOLD,
  output logic o_LOAD_DONE,
  output logic o_LOAD_ERROR,
  program_loader_if.master ram
);

  localparam int ADDR_WIDTH = $clog2(RAM_LENGTH);
  localparam int CW         = $clog2(CLKS_PER_BIT);
  localparam int BW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0]         CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]         CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]         BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] SYNC_BYTE = DATA_WIDTH'(8'hA5);
  localparam logic [DATA_WIDTH-1:0] MAX_LEN   = DATA_WIDTH'(RAM_LENGTH);

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t             rx_state_reg, rx_state_next;
  logic                  rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  byte_valid_reg, byte_valid_next;
  logic                  frame_err_reg, frame_err_next;

  // Synchronizer and edge-history flops preset high so reset looks like an idle line.
  always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      rx_prev_reg    <= 1'b1;
      rx_state_reg   <= RX_IDLE;
      cnt_reg        <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_meta_reg    <= i_RX;
      rx_sync_reg    <= rx_meta_reg;
      rx_prev_reg    <= rx_sync_reg;
      rx_state_reg   <= rx_state_next;
      cnt_reg        <= cnt_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    rx_state_next   = rx_state_reg;
    cnt_next        = cnt_reg;
    bit_next        = bit_reg;
    shift_next      = shift_reg;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_state_next = RX_START;
          cnt_next      = '0;
        end
      end
      RX_START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next      = '0;
          bit_next      = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_sync_reg, shift_reg[DATA_WIDTH-1:1]};
          if (bit_reg == BIT_LAST) rx_state_next = RX_STOP;
          else                     bit_next      = bit_reg + BW'(1);
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next        = '0;
          rx_state_next   = RX_IDLE;
          byte_valid_next = rx_sync_reg;
          frame_err_next  = !rx_sync_reg;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------- frame FSM ----------------
  typedef enum logic [1:0] {IDLE, LENGTH, DATA, CHECK} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] len_reg, len_next;
  logic [DATA_WIDTH-1:0] count_reg, count_next;
  logic [DATA_WIDTH-1:0] sum_reg, sum_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] ram_addr_reg, ram_addr_next;
  logic [DATA_WIDTH-1:0] ram_data_reg, ram_data_next;
  logic                  hold_reg, hold_next;
  logic                  done_reg, done_next;
  logic                  error_reg, error_next;

  always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      count_reg    <= '0;
      sum_reg      <= '0;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      ram_addr_reg <= '0;
      ram_data_reg <= '0;
      hold_reg     <= 1'b1;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      count_reg    <= count_next;
      sum_reg      <= sum_next;
      addr_reg     <= addr_next;
      we_reg       <= we_next;
      ram_addr_reg <= ram_addr_next;
      ram_data_reg <= ram_data_next;
      hold_reg     <= hold_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    count_next    = count_reg;
    sum_next      = sum_reg;
    addr_next     = addr_reg;
    we_next       = 1'b0;
    ram_addr_next = ram_addr_reg;
    ram_data_next = ram_data_reg;
    hold_next     = hold_reg;
    done_next     = done_reg;
    error_next    = error_reg;
    // A framing error aborts any frame in progress; in IDLE it is just line noise.
    if (frame_err_reg && state_reg != IDLE) begin
      error_next = 1'b1;
      state_next = IDLE;
    end else if (byte_valid_reg) begin
      case (state_reg)
        IDLE: begin
          if (shift_reg == SYNC_BYTE) begin
            state_next = LENGTH;
            done_next  = 1'b0;
            error_next = 1'b0;
            hold_next  = 1'b1;
            addr_next  = '0;
            sum_next   = '0;
            count_next = '0;
          end
        end
        LENGTH: begin
          if (shift_reg != '0 && shift_reg <= MAX_LEN) begin
            len_next   = shift_reg;
            state_next = DATA;
          end else begin
            error_next = 1'b1;
            state_next = IDLE;
          end
        end
        DATA: begin
          we_next       = 1'b1;
          ram_addr_next = addr_reg;
          ram_data_next = shift_reg;
          addr_next     = addr_reg + ADDR_WIDTH'(1);
          sum_next      = sum_reg + shift_reg;
          count_next    = count_reg + DATA_WIDTH'(1);
          if (count_next == len_reg) state_next = CHECK;
        end
        CHECK: begin
          state_next = IDLE;
          if (shift_reg == sum_reg) begin
            done_next = 1'b1;
            hold_next = 1'b0;
          end else begin
            error_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign ram.o_RAM_WE   = we_reg;
  assign ram.o_RAM_ADDR = ram_addr_reg;
  assign ram.o_RAM_DATA = ram_data_reg;
  assign o_CPU_HOLD     = hold_reg;
  assign o_LOAD_DONE    = done_reg;
  assign o_LOAD_ERROR   = error_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: serial frames in, RAM writes and status flags checked
// against hand-computed values.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic hold, done, err;

  program_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  program_loader #(.DATA_WIDTH(8), .RAM_LENGTH(16), .CLKS_PER_BIT(4)) dut (
    .i_SYS_CLOCK (clk),
    .i_CLEAR_n   (rst_n),
    .i_RX        (rx),
    .o_CPU_HOLD  (hold),
    .o_LOAD_DONE (done),
    .o_LOAD_ERROR(err),
    .ram         (bus)
  );

  always #5 clk = ~clk;

  // Write monitor: logs every strobe and flags back-to-back strobes or both flags high.
  int         we_total = 0;
  int         we_back2back = 0;
  int         flags_both = 0;
  logic       we_prev = 1'b0;
  logic [3:0] log_addr [64];
  logic [7:0] log_data [64];

  always @(negedge clk) begin
    if (bus.o_RAM_WE) begin
      log_addr[we_total % 64] = bus.o_RAM_ADDR;
      log_data[we_total % 64] = bus.o_RAM_DATA;
      we_total = we_total + 1;
      if (we_prev) we_back2back = we_back2back + 1;
    end
    if (done && err) flags_both = flags_both + 1;
    we_prev = bus.o_RAM_WE;
  end

  int n_checks = 0;
  int n_pass = 0;
  int base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(4);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(4);
    end
    rx = stop;
    idle(4);
    rx = 1'b1;
    idle(6);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_error"}, 32'(err), 32'(e));
    check({tag, "_hold"}, 32'(hold), 32'(h));
  endtask

  initial begin
    idle(3);
    check("rst_hold", 32'(hold), 32'd1);
    check("rst_we", 32'(bus.o_RAM_WE), 32'd0);
    check("rst_addr", 32'(bus.o_RAM_ADDR), 32'd0);
    check("rst_data", 32'(bus.o_RAM_DATA), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(err), 32'd0);
    rst_n = 1'b1;
    idle(10);

    // Good load: checksum 11+22+33 = 66
    base = we_total;
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
    send_byte(8'h66, 1'b1);
    check("ok_we_count", 32'(we_total - base), 32'd3);
    check("ok_w0_addr", 32'(log_addr[base % 64]), 32'd0);
    check("ok_w0_data", 32'(log_data[base % 64]), 32'h11);
    check("ok_w1_addr", 32'(log_addr[(base + 1) % 64]), 32'd1);
    check("ok_w1_data", 32'(log_data[(base + 1) % 64]), 32'h22);
    check("ok_w2_addr", 32'(log_addr[(base + 2) % 64]), 32'd2);
    check("ok_w2_data", 32'(log_data[(base + 2) % 64]), 32'h33);
    check_status("ok", 1'b1, 1'b0, 1'b0);
    check("ok_addr_held", 32'(bus.o_RAM_ADDR), 32'd2);
    check("ok_data_held", 32'(bus.o_RAM_DATA), 32'h33);

    // Bad checksum: 01+02 = 03, sent 04
    base = we_total;
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h04, 1'b1);
    check("csum_we_count", 32'(we_total - base), 32'd2);
    check("csum_w1_data", 32'(log_data[(base + 1) % 64]), 32'h02);
    check_status("csum", 1'b0, 1'b1, 1'b1);

    // Zero length, then a recovering frame
    base = we_total;
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1);
    check("len0_we_count", 32'(we_total - base), 32'd0);
    check_status("len0", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h5A, 1'b1); send_byte(8'h5A, 1'b1);
    check_status("len0_recover", 1'b1, 1'b0, 1'b0);

    // Length 17 exceeds the 16-word RAM
    base = we_total;
    send_byte(8'hA5, 1'b1); send_byte(8'h11, 1'b1);
    check("len17_we_count", 32'(we_total - base), 32'd0);
    check_status("len17", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h07, 1'b1); send_byte(8'h07, 1'b1);
    check_status("len17_recover", 1'b1, 1'b0, 1'b0);

    // Non-sync bytes while idle are ignored, flags untouched
    base = we_total;
    send_byte(8'h3C, 1'b1); send_byte(8'hFF, 1'b1);
    check("noise_we_count", 32'(we_total - base), 32'd0);
    check_status("noise", 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h10, 1'b1); send_byte(8'h20, 1'b1); send_byte(8'h30, 1'b1);
    check("noise_frame_we", 32'(we_total - base), 32'd2);
    check_status("noise_frame", 1'b1, 1'b0, 1'b0);

    // Framing error inside DATA: no write for the bad byte, FSM back in IDLE
    base = we_total;
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b0);
    check("frm_we_count", 32'(we_total - base), 32'd1);
    check_status("frm", 1'b0, 1'b1, 1'b1);
    send_byte(8'h09, 1'b1);
    check("frm_idle_no_we", 32'(we_total - base), 32'd1);

    // Short glitch while a data byte is expected must not become a byte
    base = we_total;
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
    rx = 1'b0; idle(2); rx = 1'b1; idle(60);
    check("glitch_we_count", 32'(we_total - base), 32'd0);
    send_byte(8'h44, 1'b1); send_byte(8'h44, 1'b1);
    check("glitch_frame_we", 32'(we_total - base), 32'd1);
    check("glitch_frame_data", 32'(log_data[base % 64]), 32'h44);
    check_status("glitch_frame", 1'b1, 1'b0, 1'b0);

    // Reset in the middle of the 2nd data byte of a 4-byte load
    base = we_total;
    send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h81, 1'b1);
    check("mid_first_write", 32'(we_total - base), 32'd1);
    rx = 1'b0; idle(4);
    rx = 1'b1; idle(4);
    rx = 1'b0; idle(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hold", 32'(hold), 32'd1);
    check("mid_rst_we", 32'(bus.o_RAM_WE), 32'd0);
    check("mid_rst_addr", 32'(bus.o_RAM_ADDR), 32'd0);
    check("mid_rst_data", 32'(bus.o_RAM_DATA), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(err), 32'd0);
    rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(120);
    check("mid_after_we", 32'(we_total - base), 32'd1);
    check_status("mid_after", 1'b0, 1'b0, 1'b1);

    check("we_back_to_back", 32'(we_back2back), 32'd0);
    check("flags_both_high", 32'(flags_both), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
